// File: rtl/aes_pkg.sv
// Shared AES-128 constants and helpers: round count, Rcon, xtime, byte access
// and the round-engine FSM encoding.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_fsm_e;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1B;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Byte 0 is the most significant byte of the 128-bit block.
  function automatic logic [7:0] get_byte(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

endpackage

// File: rtl/aes128_round_core_if.sv
// Block-level command/result bus of the AES-128 round core.
interface aes128_round_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/aes128_round_core_key_round.sv
// One step of AES-128 key expansion: previous round key + Rcon -> next round key.
module aes128_key_round
  import aes_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_out
);

  logic [31:0]  w0, w1, w2, w3, w4, w5, w6, w7;
  logic [127:0] sw_in, sw_out;
  logic         unused_sw_hi;

  assign {w0, w1, w2, w3} = key_in;

  // SubWord(RotWord(w3)) occupies the low word; the other S-box lanes idle at 0.
  assign sw_in = {96'd0, w3[23:0], w3[31:24]};

  sub_bytes u_subword (
    .data_i (sw_in),
    .data_o (sw_out)
  );

  assign unused_sw_hi = ^sw_out[127:32];

  assign w4 = w0 ^ sw_out[31:0] ^ {rcon_i, 24'd0};
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;

  assign key_out = {w4, w5, w6, w7};

endmodule

// File: rtl/sub_bytes.sv
// Combinational AES SubBytes over 16 bytes; S-box built from the GF(2^8)
// inverse (a^254) followed by the affine transform.
module sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    data_o = '0;
    for (int i = 0; i < 16; i++) data_o[8*i +: 8] = sbox(data_i[8*i +: 8]);
  end

endmodule

// File: rtl/aes128_round_core.sv
// Iterative AES-128 encryptor: one full round (SubBytes, ShiftRows, MixColumns,
// AddRoundKey with on-the-fly key expansion) per clock, ten rounds per block.
module aes128_round_core
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  aes128_round_core_if.slave  bus
);

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[127-8*(4*c+rw) -: 8] = get_byte(s, 4*((c+rw)%4) + rw);
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(s, 4*c);
      a1 = get_byte(s, 4*c+1);
      a2 = get_byte(s, 4*c+2);
      a3 = get_byte(s, 4*c+3);
      r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  aes_fsm_e     fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] ciphertext_q, ciphertext_d;
  logic [3:0]   round_cnt_q, round_cnt_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;

  logic [127:0] sb, sr, mc, nk, round_out;
  logic [7:0]   rcon_w;
  logic         last_round;

  sub_bytes u_sub_bytes (
    .data_i (state_q),
    .data_o (sb)
  );

  assign rcon_w = rcon(round_cnt_q);

  aes128_key_round u_key_round (
    .key_in  (key_q),
    .rcon_i  (rcon_w),
    .key_out (nk)
  );

  assign last_round = (round_cnt_q == 4'(AES_NR));
  assign sr         = shift_rows(sb);
  assign mc         = last_round ? sr : mix_columns(sr);
  assign round_out  = mc ^ nk;

  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    key_d        = key_q;
    ciphertext_d = ciphertext_q;
    round_cnt_d  = round_cnt_q;
    in_ready_d   = 1'b0;
    out_valid_d  = 1'b0;
    busy_d       = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          state_d     = bus.plaintext ^ bus.key;
          key_d       = bus.key;
          round_cnt_d = 4'd1;
          fsm_d       = ST_ROUND;
          in_ready_d  = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_ROUND: begin
        busy_d      = 1'b1;
        state_d     = round_out;
        key_d       = nk;
        round_cnt_d = round_cnt_q + 4'd1;
        if (last_round) begin
          ciphertext_d = round_out;
          round_cnt_d  = 4'd0;
          out_valid_d  = 1'b1;
          fsm_d        = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d      = 1'b1;
        out_valid_d = 1'b1;
        // in_ready only rises once IDLE is entered, so no same-cycle re-accept.
        if (bus.out_ready) begin
          busy_d      = 1'b0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          fsm_d       = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
    if (round_cnt_q > 4'(AES_NR)) begin
      fsm_d       = ST_IDLE;
      round_cnt_d = 4'd0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q        <= ST_IDLE;
      state_q      <= '0;
      key_q        <= '0;
      ciphertext_q <= '0;
      round_cnt_q  <= 4'd0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      key_q        <= key_d;
      ciphertext_q <= ciphertext_d;
      round_cnt_q  <= round_cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.ciphertext = ciphertext_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_aes128_round_core.sv
// Directed testbench for aes128_round_core using FIPS-197 known-answer vectors.
module tb_aes128_round_core;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  aes128_round_core_if bus ();

  aes128_round_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns positioned #1 after the acceptance edge.
  task automatic send(input logic [127:0] pt, input logic [127:0] k);
    int guard;
    guard         = 0;
    bus.plaintext = pt;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) begin
      total++;
      $error("FAIL send_timeout: observed in_ready %b expected 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int gap;
    logic [127:0] first_ct;

    reset          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.plaintext  = '0;
    bus.key        = '0;
    #1;
    chk("reset_in_ready", 128'(bus.in_ready), 128'd0);
    chk("reset_out_valid", 128'(bus.out_valid), 128'd0);
    chk("reset_busy", 128'(bus.busy), 128'd0);
    chk("reset_ciphertext", bus.ciphertext, 128'd0);
    step();
    step();
    chk("reset_held_in_ready", 128'(bus.in_ready), 128'd0);
    reset = 1'b1;
    step();
    chk("idle_in_ready", 128'(bus.in_ready), 128'd1);

    // FIPS-197 C.1 with latency check
    send(C1_PT, C1_KEY);
    chk("c1_busy", 128'(bus.busy), 128'd1);
    chk("c1_in_ready_low", 128'(bus.in_ready), 128'd0);
    wait_out(lat);
    chk("c1_latency", 128'(lat), 128'd10);
    chk("c1_ct", bus.ciphertext, C1_CT);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("c1_out_valid_drop", 128'(bus.out_valid), 128'd0);
    chk("c1_busy_drop", 128'(bus.busy), 128'd0);
    chk("c1_in_ready_back", 128'(bus.in_ready), 128'd1);

    // FIPS-197 App. B with first round key
    send(B_PT, B_KEY);
    step();
    chk("b_round1_key", dut.key_q, B_RK1);
    wait_out(lat);
    chk("b_latency", 128'(lat + 1), 128'd10);
    chk("b_ct", bus.ciphertext, B_CT);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // All-zero vector with back-pressure and ignored in_valid pulses
    send('0, '0);
    wait_out(lat);
    chk("zero_latency", 128'(lat), 128'd10);
    chk("zero_ct", bus.ciphertext, Z_CT);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid  = (i % 2 == 0);
      bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
      bus.key       = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
      chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
      chk("bp_ct", bus.ciphertext, Z_CT);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_release_out_valid", 128'(bus.out_valid), 128'd0);
    chk("bp_release_in_ready", 128'(bus.in_ready), 128'd1);
    step();
    chk("bp_no_stray_accept", 128'(bus.busy), 128'd0);

    // Back-to-back: 10 round cycles + DONE + IDLE between acceptances
    bus.out_ready = 1'b1;
    send(C1_PT, C1_KEY);
    bus.plaintext = B_PT;
    bus.key       = B_KEY;
    bus.in_valid  = 1'b1;
    first_ct      = '0;
    gap           = 0;
    while (!bus.in_ready && gap < 40) begin
      step();
      gap++;
      if (bus.out_valid) first_ct = bus.ciphertext;
    end
    chk("b2b_first_ct", first_ct, C1_CT);
    chk("b2b_accept_gap", 128'(gap + 1), 128'd12);
    step();
    bus.in_valid = 1'b0;
    chk("b2b_second_busy", 128'(bus.busy), 128'd1);
    wait_out(lat);
    chk("b2b_second_latency", 128'(lat), 128'd10);
    chk("b2b_second_ct", bus.ciphertext, B_CT);
    step();
    bus.out_ready = 1'b0;
    chk("b2b_done_exit", 128'(bus.out_valid), 128'd0);

    // Asynchronous abort in the middle of round processing
    send(C1_PT, C1_KEY);
    for (int i = 0; i < 4; i++) step();
    #2;
    reset = 1'b0;
    #1;
    chk("abort_out_valid", 128'(bus.out_valid), 128'd0);
    chk("abort_busy", 128'(bus.busy), 128'd0);
    chk("abort_ciphertext", bus.ciphertext, 128'd0);
    chk("abort_in_ready", 128'(bus.in_ready), 128'd0);
    step();
    reset = 1'b1;
    step();
    chk("abort_release_in_ready", 128'(bus.in_ready), 128'd1);
    send(C1_PT, C1_KEY);
    wait_out(lat);
    chk("abort_rerun_ct", bus.ciphertext, C1_CT);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Inputs scrambled every cycle after acceptance must not matter
    send(B_PT, B_KEY);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
      bus.key       = {$urandom, $urandom, $urandom, $urandom};
      step();
      lat++;
    end
    chk("scramble_latency", 128'(lat), 128'd10);
    chk("scramble_ct", bus.ciphertext, B_CT);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("scramble_done_exit", 128'(bus.out_valid), 128'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
